// File: rtl/bp_me_pkg.sv
// Shared ME types: processor configuration lookup, CCE-mem message layout and
// the memory responder FSM state encoding.
package bp_me_pkg;

    typedef enum logic {e_bp_inv_cfg = 1'b0} bp_params_e;

    typedef struct packed {
        int paddr_width;
        int cce_block_width;
        int lce_id_width;
        int lce_assoc;
    } bp_proc_param_s;

    function automatic bp_proc_param_s bp_get_proc_param(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_inv_cfg: p = '{paddr_width: 40, cce_block_width: 512, lce_id_width: 4, lce_assoc: 8};
            default:      p = '{paddr_width: 40, cce_block_width: 512, lce_id_width: 4, lce_assoc: 8};
        endcase
        return p;
    endfunction

    localparam bp_proc_param_s inv_cfg_gp = bp_get_proc_param(e_bp_inv_cfg);
    localparam int paddr_width_gp         = inv_cfg_gp.paddr_width;
    localparam int cce_block_width_gp     = inv_cfg_gp.cce_block_width;
    localparam int lce_id_width_gp        = inv_cfg_gp.lce_id_width;
    localparam int lce_assoc_gp           = inv_cfg_gp.lce_assoc;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_pre   = 4'd4
    } bp_cce_mem_msg_type_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0]       lce_id;
        logic [$clog2(lce_assoc_gp)-1:0]  way_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        bp_cce_mem_payload_s    payload;
        logic [2:0]             size;
        logic [paddr_width_gp-1:0] addr;
        bp_cce_mem_msg_type_e   msg_type;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        bp_cce_mem_msg_header_s        header;
    } bp_cce_mem_msg_s;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_wait = 2'd1,
        e_resp = 2'd2
    } bp_mem_resp_state_e;

endpackage

// File: rtl/bp_mem_resp_storage.sv
// Block-granular backing store: one read-modify-write port with a per-byte
// write mask and an offset/size extractor for uncached reads.
module bp_mem_resp_storage #(
    parameter int block_width_p = 512,
    parameter int els_p         = 1024,
    localparam int bytes_lp        = block_width_p / 8,
    localparam int offset_width_lp = $clog2(bytes_lp),
    localparam int idx_width_lp    = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic                       full_i,
    input  logic [idx_width_lp-1:0]    idx_i,
    input  logic [offset_width_lp-1:0] offset_i,
    input  logic [2:0]                 size_i,
    input  logic [block_width_p-1:0]   wdata_i,
    output logic [block_width_p-1:0]   rdata_o,
    output logic [block_width_p-1:0]   rdata_uc_o
);

    logic [block_width_p-1:0] mem_r [els_p];
    logic [block_width_p-1:0] wdata_shift;
    logic [block_width_p-1:0] wblock;
    logic [block_width_p-1:0] rmask;
    int                       size_bytes;

    assign rdata_o = mem_r[idx_i];

    always_comb begin
        size_bytes  = 1 << size_i;
        wdata_shift = full_i ? wdata_i : (wdata_i << {offset_i, 3'b000});
        wblock      = rdata_o;
        rmask       = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            // Sizes larger than the block simply select every remaining byte.
            if (i < size_bytes) rmask[i*8 +: 8] = 8'hff;
            if (full_i || ((i >= int'(offset_i)) && (i < int'(offset_i) + size_bytes)))
                wblock[i*8 +: 8] = wdata_shift[i*8 +: 8];
        end
        rdata_uc_o = (rdata_o >> {offset_i, 3'b000}) & rmask;
    end

    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_r[idx_i] <= wblock;
    end

endmodule

// File: rtl/bp_mem_cmd_responder.sv
// Memory end of the CCE-mem link: one command at a time, programmable latency.
// Define BP_MEM_RESP_JITTER_EN to add 0..7 cycles of LFSR-driven latency jitter.
module bp_mem_cmd_responder
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int latency_p = 4,
    parameter int mem_els_p = 1024,
    localparam bp_proc_param_s proc_param_lp = bp_get_proc_param(bp_params_p),
    localparam int cce_block_width_p    = proc_param_lp.cce_block_width,
    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s),
    localparam int offset_width_lp      = $clog2(cce_block_width_p / 8),
    localparam int idx_width_lp         = $clog2(mem_els_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,
    output bp_mem_resp_state_e              state_o
);

    // Handshake: a command transfers on a cycle with mem_cmd_v_i & mem_cmd_ready_o;
    // a response transfers on a cycle with mem_resp_v_o & mem_resp_yumi_i.

    bp_mem_resp_state_e       state_r, state_n;
    bp_cce_mem_msg_s          cmd_li, cmd_r, resp_r;
    logic [8:0]               cnt_r, cnt_load;
    logic                     accept, exec, st_w_v, st_full;
    logic [cce_block_width_p-1:0] rdata_block, rdata_uc, resp_data;

    assign cmd_li     = mem_cmd_i;
    assign mem_resp_o = resp_r;
    assign state_o    = state_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n         = state_r;
        mem_cmd_ready_o = 1'b0;
        mem_resp_v_o    = 1'b0;
        case (state_r)
            e_idle: begin
                mem_cmd_ready_o = 1'b1;
                if (mem_cmd_v_i) state_n = e_wait;
            end
            e_wait: if (cnt_r == '0) state_n = e_resp;
            e_resp: begin
                mem_resp_v_o = 1'b1;
                if (mem_resp_yumi_i) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    assign accept = mem_cmd_ready_o & mem_cmd_v_i;
    assign exec   = (state_r == e_wait) && (cnt_r == '0);

`ifdef BP_MEM_RESP_JITTER_EN
    logic [7:0] lfsr_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     lfsr_r <= 8'h01;
        else if (accept) lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end

    // The value in place at accept time sets this command's extra latency.
    assign cnt_load = 9'(latency_p - 1) + 9'(lfsr_r[2:0]);
`else
    assign cnt_load = 9'(latency_p - 1);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_r  <= '0;
            resp_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (accept) begin
                cmd_r <= cmd_li;
                cnt_r <= cnt_load;
            end else if ((state_r == e_wait) && (cnt_r != '0)) begin
                cnt_r <= cnt_r - 9'd1;
            end
            if (exec) begin
                resp_r.header <= cmd_r.header;
                resp_r.data   <= resp_data;
            end
        end
    end

    always_comb begin
        case (cmd_r.header.msg_type)
            e_cce_mem_rd:    resp_data = rdata_block;
            e_cce_mem_uc_rd: resp_data = rdata_uc;
            default:         resp_data = '0;
        endcase
    end

    assign st_full = (cmd_r.header.msg_type == e_cce_mem_wr);
    assign st_w_v  = exec && (st_full || (cmd_r.header.msg_type == e_cce_mem_uc_wr));

    bp_mem_resp_storage #(
        .block_width_p(cce_block_width_p),
        .els_p        (mem_els_p)
    ) storage (
        .clk_i     (clk_i),
        .w_v_i     (st_w_v),
        .full_i    (st_full),
        .idx_i     (cmd_r.header.addr[offset_width_lp +: idx_width_lp]),
        .offset_i  (cmd_r.header.addr[offset_width_lp-1:0]),
        .size_i    (cmd_r.header.size),
        .wdata_i   (cmd_r.data),
        .rdata_o   (rdata_block),
        .rdata_uc_o(rdata_uc)
    );

endmodule

// File: tb/tb_bp_mem_cmd_responder.sv
// Self-checking bench for bp_mem_cmd_responder: scoreboard of expected
// response headers, data and latencies, plus reset and backpressure checks.
module tb_bp_mem_cmd_responder;
    import bp_me_pkg::*;

    localparam int latency_lp = 4;
    localparam int msg_w      = $bits(bp_cce_mem_msg_s);
    localparam int bw         = cce_block_width_gp;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [msg_w-1:0] mem_cmd = '0;
    logic             cmd_v = 1'b0;
    logic             ready;
    logic [msg_w-1:0] mem_resp;
    logic             resp_v;
    logic             yumi = 1'b0;
    bp_mem_resp_state_e state;
    bp_cce_mem_msg_s  resp_s;

    assign resp_s = mem_resp;

    always #5 clk = ~clk;

    bp_mem_cmd_responder #(
        .bp_params_p(e_bp_inv_cfg),
        .latency_p  (latency_lp),
        .mem_els_p  (1024)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .mem_cmd_i      (mem_cmd),
        .mem_cmd_v_i    (cmd_v),
        .mem_cmd_ready_o(ready),
        .mem_resp_o     (mem_resp),
        .mem_resp_v_o   (resp_v),
        .mem_resp_yumi_i(yumi),
        .state_o        (state)
    );

    int total = 0;
    int bad   = 0;
    logic [bw-1:0]          exp_q[$];
    bp_cce_mem_msg_header_s hdr_q[$];
    int                     lat_q[$];
`ifdef BP_MEM_RESP_JITTER_EN
    logic [7:0] lfsr_m = 8'h01;
`endif

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [bw-1:0] rand_blk();
        logic [bw-1:0] b;
        for (int i = 0; i < bw / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic reset_dut();
        rst   = 1'b1;
        cmd_v = 1'b0;
        yumi  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef BP_MEM_RESP_JITTER_EN
        lfsr_m = 8'h01;
`endif
    endtask

    function automatic bp_cce_mem_msg_s make_cmd(input bp_cce_mem_msg_type_e t, input logic [39:0] addr,
                                                 input logic [2:0] size, input logic [bw-1:0] data);
        bp_cce_mem_msg_s m;
        m.header.msg_type       = t;
        m.header.addr           = addr;
        m.header.size           = size;
        m.header.payload.lce_id = 4'($urandom_range(0, 15));
        m.header.payload.way_id = 3'($urandom_range(0, 7));
        m.data                  = data;
        return m;
    endfunction

    // Drive one command, then collect and score its response; hold delays yumi.
    task automatic send_cmd(input bp_cce_mem_msg_type_e t, input logic [39:0] addr, input logic [2:0] size,
                            input logic [bw-1:0] data, input logic [bw-1:0] exp_data, input int hold);
        bp_cce_mem_msg_s  m;
        logic [msg_w-1:0] snap;
        int guard, lat, exp_lat;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("cmd_ready", 512'(ready), 512'(1));
        m       = make_cmd(t, addr, size, data);
        mem_cmd = m;
        cmd_v   = 1'b1;
        exp_lat = latency_lp + 1;
`ifdef BP_MEM_RESP_JITTER_EN
        exp_lat = latency_lp + 1 + int'(lfsr_m[2:0]);
        lfsr_m  = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
        exp_q.push_back(exp_data);
        hdr_q.push_back(m.header);
        lat_q.push_back(exp_lat);
        @(negedge clk);
        cmd_v = 1'b0;
        lat   = 1;
        while (!resp_v && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check_val("resp_latency", 512'(lat), 512'(lat_q.pop_front()));
`ifdef BP_MEM_RESP_JITTER_EN
        check_val("jitter_range", 512'((lat - 1 >= 4) && (lat - 1 <= 11)), 512'(1));
`endif
        check_val("resp_header", 512'(resp_s.header), 512'(hdr_q.pop_front()));
        check_val("resp_data", resp_s.data, exp_q.pop_front());
        snap = mem_resp;
        repeat (hold) begin
            @(negedge clk);
            check_val("hold_stable", 512'({resp_v, ready, mem_resp === snap}), 512'(3'b101));
        end
        yumi = 1'b1;
        @(negedge clk);
        yumi = 1'b0;
        check_val("ready_after_yumi", 512'({ready, resp_v}), 512'(2'b10));
    endtask

    initial begin
        logic [bw-1:0] blk_a, blk_a_mod, blk_b, blk_d, ref_blk, w, exp_uc;
        bp_cce_mem_msg_s m;
        int off, sz, n;

        // Reset values while reset is held
        @(negedge clk);
        check_val("rst_ready", 512'(ready), 512'(1));
        check_val("rst_resp_v", 512'(resp_v), 512'(0));
        check_val("rst_resp", 512'(resp_s.header), 512'(0));
        check_val("rst_resp_data", resp_s.data, '0);
        check_val("rst_state", 512'(state), 512'(e_idle));
        reset_dut();

        blk_a = rand_blk();
        send_cmd(e_cce_mem_wr, 40'h80_0000_0040, 3'd6, blk_a, '0, 0);
        send_cmd(e_cce_mem_rd, 40'h80_0000_0040, 3'd6, rand_blk(), blk_a, 0);

        w = rand_blk();
        w[31:0] = 32'hdeadbeef;
        blk_a_mod = blk_a;
        blk_a_mod[32 +: 32] = 32'hdeadbeef;
        send_cmd(e_cce_mem_uc_wr, 40'h80_0000_0044, 3'd2, w, '0, 0);
        send_cmd(e_cce_mem_uc_rd, 40'h80_0000_0044, 3'd2, rand_blk(), bw'(32'hdeadbeef), 0);
        send_cmd(e_cce_mem_rd, 40'h80_0000_0040, 3'd6, '0, blk_a_mod, 0);
        send_cmd(e_cce_mem_uc_rd, 40'h80_0000_0045, 3'd0, '0, bw'(8'hbe), 0);
        send_cmd(e_cce_mem_uc_rd, 40'h80_0000_0078, 3'd3, '0, bw'(blk_a_mod[511:448]), 0);
        send_cmd(e_cce_mem_uc_rd, 40'h80_0000_0040, 3'd6, '0, blk_a_mod, 0);

        // Block index ignores address bits above the 1024-block window
        blk_d = rand_blk();
        send_cmd(e_cce_mem_wr, 40'h00_0000_0000, 3'd6, blk_d, '0, 0);
        send_cmd(e_cce_mem_rd, 40'h00_0001_0000, 3'd6, '0, blk_d, 0);

        send_cmd(e_cce_mem_pre, 40'h80_0000_0040, 3'd6, rand_blk(), '0, 0);
        send_cmd(e_cce_mem_rd, 40'h80_0000_0040, 3'd6, '0, blk_a_mod, 20);

        // Reset while a write is waiting: the write must be dropped
        blk_b = rand_blk();
        send_cmd(e_cce_mem_wr, 40'h80_0000_0100, 3'd6, blk_b, '0, 0);
        m       = make_cmd(e_cce_mem_wr, 40'h80_0000_0100, 3'd6, rand_blk());
        mem_cmd = m;
        cmd_v   = 1'b1;
        @(negedge clk);
        cmd_v = 1'b0;
        @(negedge clk);
        check_val("mid_wait_state", 512'(state), 512'(e_wait));
        rst = 1'b1;
        #1;
        check_val("mid_rst_ready", 512'({ready, resp_v}), 512'(2'b10));
        check_val("mid_rst_resp", 512'(resp_s.header), 512'(0));
        check_val("mid_rst_state", 512'(state), 512'(e_idle));
        @(negedge clk);
        rst = 1'b0;
`ifdef BP_MEM_RESP_JITTER_EN
        lfsr_m = 8'h01;
`endif
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_v) n++;
        end
        check_val("no_resp_after_rst", 512'(n), 512'(0));
        send_cmd(e_cce_mem_rd, 40'h80_0000_0100, 3'd6, '0, blk_b, 0);

        // Random uncached writes against a byte-level reference block
        ref_blk = rand_blk();
        send_cmd(e_cce_mem_wr, 40'h80_0000_0200, 3'd6, ref_blk, '0, 0);
        for (int k = 0; k < 4; k++) begin
            sz  = $urandom_range(0, 3);
            off = $urandom_range(0, 64 - (1 << sz));
            w   = rand_blk();
            for (int b = 0; b < (1 << sz); b++) ref_blk[(off + b)*8 +: 8] = w[b*8 +: 8];
            send_cmd(e_cce_mem_uc_wr, 40'h80_0000_0200 + 40'(off), 3'(sz), w, '0, 0);
            exp_uc = '0;
            for (int b = 0; b < (1 << sz); b++) exp_uc[b*8 +: 8] = ref_blk[(off + b)*8 +: 8];
            send_cmd(e_cce_mem_uc_rd, 40'h80_0000_0200 + 40'(off), 3'(sz), '0, exp_uc, 0);
        end
        send_cmd(e_cce_mem_rd, 40'h80_0000_0200, 3'd6, '0, ref_blk, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
